serial_rx_buffered: RTL and testbench
=====================================

# serial_rx_buffered

Oversampling serial-line receiver with an integrated byte FIFO. It sits at the far end of a serial link from our serial transmitter and deframes 8N1 frames (idle high, start 0, 8 data bits LSB first, stop 1) from `serial_line`. It buffers the received bytes and presents them on a first-word-fall-through read port (`data_output`/`no_data`/`read`), which matches the consumer-side handshake already used across the serial path. It also adds glitch rejection, framing-error and overflow reporting.

## Interface
- `CLKS_PER_BIT`, 4: clocks per bit period; even, ≥ 4.
- `FIFO_DEPTH`, 4: byte entries; power of two, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- `serial_line` in 1: asynchronous serial input, idle high.
- `read` in 1: pop request; honoured only when `no_data`=0.
- `data_output` out 8: FIFO head byte, valid while `no_data`=0.
- `no_data` out 1: FIFO empty.
- `frame_error` out 1: one-cycle pulse, stop bit sampled 0.
- `overflow` out 1: one-cycle pulse, completed byte dropped because FIFO full.

## Operation
- Input path: 2-flop synchronizer, reset to 1, feeding `line_s`. A `prev` flop (reset 1) drives falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START on `prev`=1 && `line_s`=0. Bit counter cleared. A line held low never retriggers.
- START: at count N/2−1 (N = CLKS_PER_BIT), sample `line_s`.
  - 0: go to DATA, counter cleared.
  - 1: glitch; return to IDLE with no outputs.
- DATA: sample every N clocks and shift into bit[idx], LSB first. After 8 samples, go to STOP.
- STOP: sample after N clocks, then return to IDLE unconditionally.
  - 1: push byte.
  - 0: pulse `frame_error`, no push.
- Sample points, relative to the first cycle with `line_s`=0 (offset 0): N/2−1+k·N for k=0 (start), k=1..8 (data), k=9 (stop).
- FIFO behaviour:
  - FWFT: head is always on `data_output`.
  - `read` && !`no_data` pops at the clock edge.
  - `read` while empty is ignored.
- Push while full:
  - With a simultaneous pop: both happen, count unchanged, no overflow.
  - Without a pop: byte dropped, `overflow` pulses, FIFO contents unchanged.
- Push and pop on a non-full, non-empty FIFO: count unchanged.
- Push into an empty FIFO: `no_data` falls the next cycle; no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a log2(DEPTH)+1-bit count.

## Timing
- Reset values:
  - FSM: IDLE.
  - FIFO: empty; `no_data`=1, `data_output`=8'h00.
  - `frame_error`=0, `overflow`=0.
  - Sync and `prev` flops: 1. Shift register: 0.
- Reset mid-frame aborts the frame. The partial byte is discarded and FIFO contents are lost.
- Latency: let E0 be the first rising edge that samples `serial_line`=0. The byte is pushed at edge E0+2+N/2+9N−1, and `no_data` is 0 after that edge. For N=4, that is edge E0+39.
- Back-to-back frames: a start edge arriving any time after the STOP sample is accepted. IDLE costs ≤ 1 cycle, which tolerates a stop bit shortened by up to N/2−1 clocks.
- `frame_error` and `overflow` are registered, each high for exactly one cycle, in the cycle following the STOP sample.
- Pop-to-next-head: the new head appears on `data_output` the cycle after the popping edge.

## Structure
- Package `serial_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP).
  - `SERIAL_DATA_BITS`=8, `SERIAL_IDLE_LEVEL`=1'b1, `SERIAL_START_LEVEL`=1'b0.
  - Shared with the transmitter.
- Sub-module `serial_byte_fifo`:
  - Parameter DEPTH; ports clk, rst_n, push, din, pop, dout, empty, full.
  - Reusable on the transmit side.
- Deframer FSM, synchronizer and error pulses live in the top.

## Test plan
- Single frame 0x68 ('h'), N=4, line otherwise idle → `no_data` low after edge E0+39, `data_output`=0x68; `read` 1 cycle → `no_data`=1.
- Five back-to-back frames "hello" with `read` held 0, DEPTH=4 → 'h','e','l','l' buffered; fifth frame pulses `overflow` once; reads return h,e,l,l in order.
- Same five frames with `read` asserted the cycle the fifth push occurs while full → no `overflow`; reads return e,l,l,o.
- Frame 0x55 with stop bit driven 0 → `frame_error` pulses once, `no_data` stays 1; the following valid frame 0x6F is received correctly.
- 1-clock low glitch on idle line, then line low for 20 clocks then high → no push, no `frame_error`, FSM returns to IDLE; only the low period with a valid frame shape is decoded.
- `rst_n` low for 1 cycle at data bit 4 of frame 0x77, with two bytes already buffered → `no_data`=1 after reset; the next full frame 0x64 is received as 0x64.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive path: 8N1 framing
// constants and the deframer state encoding.
package serial_pkg;

    localparam int   SERIAL_DATA_BITS   = 8;
    localparam logic SERIAL_IDLE_LEVEL  = 1'b1;
    localparam logic SERIAL_START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_e;

endpackage

// File: rtl/serial_byte_fifo.sv
// First-word-fall-through byte FIFO; the head entry is always on dout and
// reads as 8'h00 while empty.
module serial_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_rx_buffered.sv
// Oversampling 8N1 receiver with glitch rejection, framing-error and overflow
// pulses, feeding a first-word-fall-through byte FIFO.
module serial_rx_buffered
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_line,
    input  logic       read,
    output logic [7:0] data_output,
    output logic       no_data,
    output logic       frame_error,
    output logic       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(SERIAL_DATA_BITS - 1);

    serial_state_e state;
    logic          sync_p0;
    logic          line_s;
    logic          prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          stop_sample;
    logic          push;
    logic          fifo_full;

    // Synchronizer stage: serial_line -> sync_p0 -> line_s, plus edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= SERIAL_IDLE_LEVEL;
            line_s  <= SERIAL_IDLE_LEVEL;
            prev    <= SERIAL_IDLE_LEVEL;
        end else begin
            sync_p0 <= serial_line;
            line_s  <= sync_p0;
            prev    <= line_s;
        end
    end

    assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
    assign push        = stop_sample && (line_s == SERIAL_IDLE_LEVEL);

    // Deframer stage: the detect cycle counts as offset 0, so START begins at 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (prev == SERIAL_IDLE_LEVEL && line_s == SERIAL_START_LEVEL) begin
                        state <= START;
                        cnt   <= CW'(1);
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= (line_s == SERIAL_START_LEVEL) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= line_s;
                        if (bit_idx == IDX_LAST) state <= STOP;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error pulse stage: one cycle after the stop sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_error <= stop_sample && (line_s != SERIAL_IDLE_LEVEL);
            overflow    <= push && fifo_full && !read;
        end
    end

    serial_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shift),
        .pop   (read),
        .dout  (data_output),
        .empty (no_data),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_serial_rx_buffered.sv
// Scoreboard bench for serial_rx_buffered: frames are driven on serial_line,
// expected bytes queued, and popped/compared as the FIFO is read.
module tb_serial_rx_buffered;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int PUSH_EDGE = 2 + N/2 + 9*N - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_line;
    logic       read;
    logic [7:0] data_output;
    logic       no_data;
    logic       frame_error;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt  = 0;
    int ferr_cnt = 0;
    int exp_ovf  = 0;
    int exp_ferr = 0;
    logic [7:0] sb_q [$];

    serial_rx_buffered #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_line (serial_line),
        .read        (read),
        .data_output (data_output),
        .no_data     (no_data),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow)    ovf_cnt  = ovf_cnt + 1;
        if (frame_error) ferr_cnt = ferr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int nbits);
        serial_line = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            serial_line = b[i];
            repeat (N) @(posedge clk);
            #1;
        end
        if (nbits == 8) begin
            serial_line = stop_lvl;
            repeat (N) @(posedge clk);
            #1;
            serial_line = 1'b1;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b);
        send_frame(b, 1'b1, 8);
        if (sb_q.size() < DEPTH) sb_q.push_back(b);
        else                     exp_ovf++;
    endtask

    task automatic idle_cycles(input int n);
        serial_line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        int waited = 0;
        while (no_data && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (no_data) begin
            chk({tag, "_timeout"}, no_data, 1'b0);
        end else if (sb_q.size() == 0) begin
            chk({tag, "_unexpected"}, {24'h0, data_output}, 32'hFFFF_FFFF);
        end else begin
            chk(tag, {24'h0, data_output}, {24'h0, sb_q.pop_front()});
            read = 1'b1;
            @(posedge clk);
            #1;
            read = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        serial_line = 1'b1;
        read        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_no_data", no_data, 1'b1);
        chk("rst_data", {24'h0, data_output}, 32'h0);
        chk("rst_ferr", frame_error, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        idle_cycles(4);

        // Single frame with latency check at E0+PUSH_EDGE
        fork
            rx_frame(8'h68);
            begin
                @(posedge clk);
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                chk("lat_before", no_data, 1'b1);
                @(posedge clk);
                #1;
                chk("lat_after", no_data, 1'b0);
                chk("lat_data", {24'h0, data_output}, 32'h68);
            end
        join
        pop_check("h_single");
        chk("h_empty", no_data, 1'b1);
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        chk("rd_empty_ignored", no_data, 1'b1);
        chk("rd_empty_data", {24'h0, data_output}, 32'h0);
        idle_cycles(4);

        // Five back-to-back frames into a 4-deep FIFO, no reads
        rx_frame("h");
        rx_frame("e");
        rx_frame("l");
        rx_frame("l");
        rx_frame("o");
        idle_cycles(4);
        chk("ovf_count", ovf_cnt, exp_ovf);
        chk("ovf_expected_once", exp_ovf, 1);
        for (int i = 0; i < DEPTH; i++) pop_check("hello_drop");
        chk("hello_drop_empty", no_data, 1'b1);
        idle_cycles(4);

        // Same frames with a pop on the edge of the fifth push
        rx_frame("h");
        rx_frame("e");
        rx_frame("l");
        rx_frame("l");
        fork
            rx_frame("o");
            begin
                @(posedge clk);
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                read = 1'b1;
                chk("simul_pop", {24'h0, data_output}, {24'h0, sb_q.pop_front()});
                @(posedge clk);
                #1;
                read = 1'b0;
            end
        join
        idle_cycles(4);
        chk("simul_no_ovf", ovf_cnt, exp_ovf);
        for (int i = 0; i < DEPTH; i++) pop_check("hello_pop");
        chk("hello_pop_empty", no_data, 1'b1);
        idle_cycles(4);

        // Framing error then a good frame
        send_frame(8'h55, 1'b0, 8);
        exp_ferr++;
        idle_cycles(2 * N);
        chk("ferr_count", ferr_cnt, exp_ferr);
        chk("ferr_no_push", no_data, 1'b1);
        rx_frame(8'h6F);
        pop_check("after_ferr");
        chk("after_ferr_empty", no_data, 1'b1);
        idle_cycles(4);

        // One-clock glitch is rejected
        serial_line = 1'b0;
        @(posedge clk);
        #1;
        serial_line = 1'b1;
        idle_cycles(4 * N);
        chk("glitch_no_push", no_data, 1'b1);
        chk("glitch_no_ferr", ferr_cnt, exp_ferr);
        // 20 low clocks cover start + bits 0..3; bits 4..7 and stop sample high.
        serial_line = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle_cycles(12 * N);
        sb_q.push_back(8'hF0);
        chk("long_low_no_ferr", ferr_cnt, exp_ferr);
        pop_check("long_low");
        chk("long_low_empty", no_data, 1'b1);
        idle_cycles(4);

        // Reset mid-frame with two bytes buffered
        rx_frame(8'h61);
        rx_frame(8'h62);
        chk("pre_rst_buffered", no_data, 1'b0);
        send_frame(8'h77, 1'b1, 4);
        serial_line = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        chk("mid_rst_no_data", no_data, 1'b1);
        chk("mid_rst_data", {24'h0, data_output}, 32'h0);
        idle_cycles(4 * N);
        chk("mid_rst_still_empty", no_data, 1'b1);
        rx_frame(8'h64);
        pop_check("after_rst");
        chk("after_rst_empty", no_data, 1'b1);
        chk("final_ovf", ovf_cnt, exp_ovf);
        chk("final_ferr", ferr_cnt, exp_ferr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
